// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-side memory responder.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    localparam logic [2:0] LEN_B = 3'b001;
    localparam logic [2:0] LEN_H = 3'b010;
    localparam logic [2:0] LEN_W = 3'b100;

    function automatic logic [3:0] byte_en(input logic [2:0] len, input logic [1:0] lo);
        case (len)
            LEN_B:   byte_en = 4'b0001 << lo;
            LEN_H:   byte_en = lo[1] ? 4'b1100 : 4'b0011;
            LEN_W:   byte_en = 4'b1111;
            default: byte_en = 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/dmem_byte_ram.sv
// Single-port word RAM with per-byte write enables and a registered read port.
module dmem_byte_ram #(
    parameter int MEM_WORDS = 1024,
    parameter int AW        = $clog2(MEM_WORDS)
) (
    input  logic          clk,
    input  logic [3:0]    we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [MEM_WORDS];

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (we[b]) begin
                mem[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-bus slave: latches a request, waits WAIT_STATES cycles, commits it to the
// on-chip RAM and holds the pipeline via HLT until the access completes.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_2000,
    parameter int          MEM_WORDS   = 1024,
    parameter int          WAIT_STATES = 1
) (
    input  logic        CLK,
    input  logic        RESN,
    input  logic        DAS,
    input  logic        DRD,
    input  logic        DWR,
    input  logic        DRW,
    input  logic [31:0] DADDR,
    input  logic [31:0] DATAO,
    input  logic [2:0]  DLEN,
    input  logic        DERR_CLR,
    output logic [31:0] DATAI,
    output logic        HLT,
    output logic        DERR
);

    localparam int          AW        = $clog2(MEM_WORDS);
    localparam logic [31:0] MEM_BYTES = 32'(4 * MEM_WORDS);

    state_t      state, state_nxt;
    logic        hlt_int;
    logic [3:0]  count;
    logic        commit;

    logic [31:0] addr_p0, wdata_p0;
    logic [2:0]  len_p0;
    logic        rd_p0, wr_p0, rw_p0;
    logic [31:0] rdata_p1;

    logic [31:0] offset, ram_src;
    logic [AW-1:0] ram_idx;
    logic        in_window, bad_len, bad_align, bad_dir, err;
    logic [3:0]  ram_we;
    logic [31:0] ram_wdata, load_data;

    always_ff @(posedge CLK or negedge RESN) begin
        if (!RESN) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        hlt_int   = 1'b0;
        case (state)
            IDLE: begin
                hlt_int = DAS;
                if (DAS) state_nxt = BUSY;
            end
            BUSY: begin
                hlt_int = 1'b1;
                if (count == 4'd0) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign HLT    = RESN & hlt_int;
    assign commit = (state == BUSY) && (count == 4'd0);

    always_ff @(posedge CLK or negedge RESN) begin
        if (!RESN) begin
            count <= 4'd0;
        end else if (state == IDLE && DAS) begin
            count <= 4'(WAIT_STATES);
        end else if (state == BUSY && count != 4'd0) begin
            count <= count - 4'd1;
        end
    end

    // Request capture; the initiator may change its outputs afterwards
    always_ff @(posedge CLK) begin
        if (state == IDLE && DAS) begin
            addr_p0  <= DADDR;
            wdata_p0 <= DATAO;
            len_p0   <= DLEN;
            rd_p0    <= DRD;
            wr_p0    <= DWR;
            rw_p0    <= DRW;
        end
    end

    // RAM read starts on the request edge so the word is ready even with zero wait states
    assign ram_src = (state == IDLE) ? DADDR : addr_p0;
    assign ram_idx = AW'((ram_src - BASE_ADDR) >> 2);

    assign offset    = addr_p0 - BASE_ADDR;
    assign in_window = (addr_p0 >= BASE_ADDR) && (offset < MEM_BYTES);
    assign bad_len   = !(len_p0 inside {LEN_B, LEN_H, LEN_W});
    assign bad_align = (len_p0 == LEN_H && addr_p0[0]) ||
                       (len_p0 == LEN_W && addr_p0[1:0] != 2'b00);
    assign bad_dir   = (rd_p0 == wr_p0) || (rw_p0 != wr_p0);
    assign err       = !in_window || bad_len || bad_align || bad_dir;

    assign ram_we = (commit && wr_p0 && !err) ? byte_en(len_p0, addr_p0[1:0]) : 4'b0000;

    always_comb begin
        case (len_p0)
            LEN_B:   ram_wdata = {4{wdata_p0[7:0]}};
            LEN_H:   ram_wdata = {2{wdata_p0[15:0]}};
            default: ram_wdata = wdata_p0;
        endcase
    end

    always_comb begin
        case (len_p0)
            LEN_B:   load_data = {24'b0, 8'(rdata_p1 >> {addr_p0[1:0], 3'b000})};
            LEN_H:   load_data = {16'b0, (addr_p0[1] ? rdata_p1[31:16] : rdata_p1[15:0])};
            default: load_data = rdata_p1;
        endcase
    end

    dmem_byte_ram #(
        .MEM_WORDS (MEM_WORDS),
        .AW        (AW)
    ) u_ram (
        .clk   (CLK),
        .we    (ram_we),
        .addr  (ram_idx),
        .wdata (ram_wdata),
        .rdata (rdata_p1)
    );

    always_ff @(posedge CLK or negedge RESN) begin
        if (!RESN) begin
            DATAI <= 32'd0;
        end else if (commit) begin
            if (err)        DATAI <= 32'd0;
            else if (rd_p0) DATAI <= load_data;
        end
    end

    // A fresh error outranks a same-cycle clear
    always_ff @(posedge CLK or negedge RESN) begin
        if (!RESN)               DERR <= 1'b0;
        else if (commit && err)  DERR <= 1'b1;
        else if (DERR_CLR)       DERR <= 1'b0;
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (0 and 1 wait states) against a byte-array model.
module tb_dmem_responder;
    import dmem_pkg::*;

    localparam logic [31:0] BASE = 32'h0000_2000;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic        resn [2], das [2], drd [2], dwr [2], drw [2], derr_clr [2];
    logic        hlt [2], derr [2];
    logic [31:0] daddr [2], datao [2], datai [2];
    logic [2:0]  dlen [2];

    int errors = 0;
    int checks = 0;

    logic [7:0]  mdl [2][4096];
    logic [31:0] exp_datai [2];
    logic        exp_derr [2];

    dmem_responder #(.BASE_ADDR(BASE), .MEM_WORDS(1024), .WAIT_STATES(0)) u_ws0 (
        .CLK(CLK), .RESN(resn[0]), .DAS(das[0]), .DRD(drd[0]), .DWR(dwr[0]), .DRW(drw[0]),
        .DADDR(daddr[0]), .DATAO(datao[0]), .DLEN(dlen[0]), .DERR_CLR(derr_clr[0]),
        .DATAI(datai[0]), .HLT(hlt[0]), .DERR(derr[0]));

    dmem_responder #(.BASE_ADDR(BASE), .MEM_WORDS(1024), .WAIT_STATES(1)) u_ws1 (
        .CLK(CLK), .RESN(resn[1]), .DAS(das[1]), .DRD(drd[1]), .DWR(dwr[1]), .DRW(drw[1]),
        .DADDR(daddr[1]), .DATAO(datao[1]), .DLEN(dlen[1]), .DERR_CLR(derr_clr[1]),
        .DATAI(datai[1]), .HLT(hlt[1]), .DERR(derr[1]));

    // Reference: little-endian byte store over the window; any rule violation -> error
    function automatic void model_access(input int u, input logic rd, input logic wr, input logic rw,
                                         input logic [31:0] a, input logic [2:0] len, input logic [31:0] wd);
        int n;
        bit bad;
        logic [31:0] off, r;
        off = a - BASE;
        n = (len == 3'd1) ? 1 : (len == 3'd2) ? 2 : (len == 3'd4) ? 4 : 0;
        bad = (a < BASE) || (off >= 32'd4096) || (n == 0) || (rd == wr) || (rw != wr);
        if (!bad && (off % 32'(n)) != 0) bad = 1;
        if (bad) begin
            exp_datai[u] = 32'd0;
            exp_derr[u]  = 1'b1;
        end else if (wr) begin
            for (int k = 0; k < n; k++) mdl[u][off + 32'(k)] = wd[8*k +: 8];
        end else begin
            r = 32'd0;
            for (int k = 0; k < n; k++) r[8*k +: 8] = mdl[u][off + 32'(k)];
            exp_datai[u] = r;
        end
    endfunction

    task automatic access(input int u, input logic rd, input logic wr, input logic rw,
                          input logic [31:0] a, input logic [2:0] len, input logic [31:0] wd,
                          input bit hold, output logic [31:0] rdat, output logic de, output int hc);
        bit done;
        @(negedge CLK);
        drd[u] = rd; dwr[u] = wr; drw[u] = rw; daddr[u] = a; dlen[u] = len; datao[u] = wd;
        das[u] = 1'b1;
        #1;
        hc = hlt[u] ? 1 : 0;
        rdat = 'x;
        de = 1'bx;
        done = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(posedge CLK); #1;
            if (!hlt[u]) begin
                rdat = datai[u];
                de = derr[u];
                done = 1;
                if (!hold) das[u] = 1'b0;
            end else begin
                hc++;
                daddr[u] = $urandom; datao[u] = $urandom; dlen[u] = 3'($urandom_range(0, 7));
                drd[u] = 1'($urandom_range(0, 1)); dwr[u] = 1'($urandom_range(0, 1));
            end
        end
        if (!done) hc = -1;
        model_access(u, rd, wr, rw, a, len, wd);
        @(posedge CLK); #1;
    endtask

    task automatic test_reset();
        for (int u = 0; u < 2; u++) begin
            das[u] = 1'b1; drd[u] = 1'b1; dwr[u] = 1'b0; drw[u] = 1'b0;
            daddr[u] = BASE; datao[u] = 32'd0; dlen[u] = LEN_W; derr_clr[u] = 1'b0;
            resn[u] = 1'b1;
        end
        #1;
        resn[0] = 1'b0; resn[1] = 1'b0;
        #2;
        for (int u = 0; u < 2; u++) begin
            checks++; if (hlt[u] !== 1'b0) begin errors++; $display("FAIL reset_hlt[%0d]: got %b want 0", u, hlt[u]); end
            checks++; if (datai[u] !== 32'd0) begin errors++; $display("FAIL reset_datai[%0d]: got %h want 0", u, datai[u]); end
            checks++; if (derr[u] !== 1'b0) begin errors++; $display("FAIL reset_derr[%0d]: got %b want 0", u, derr[u]); end
            exp_datai[u] = 32'd0;
            exp_derr[u] = 1'b0;
        end
        das[0] = 1'b0; das[1] = 1'b0;
        @(negedge CLK);
        resn[0] = 1'b1; resn[1] = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        for (int u = 0; u < 2; u++) begin
            checks++; if (hlt[u] !== 1'b0) begin errors++; $display("FAIL idle_hlt[%0d]: got %b want 0", u, hlt[u]); end
        end
    endtask

    task automatic test_word_byte_half();
        logic [31:0] r; logic de; int hc;
        access(1, 1'b0, 1'b1, 1'b1, 32'h2000, LEN_W, 32'hDEADBEEF, 1'b0, r, de, hc);
        checks++; if (hc !== 3) begin errors++; $display("FAIL sw_hlt_cycles: got %0d want 3", hc); end
        checks++; if (de !== 1'b0) begin errors++; $display("FAIL sw_derr: got %b want 0", de); end
        access(1, 1'b1, 1'b0, 1'b0, 32'h2000, LEN_W, 32'h0, 1'b0, r, de, hc);
        checks++; if (hc !== 3) begin errors++; $display("FAIL lw_hlt_cycles: got %0d want 3", hc); end
        checks++; if (r !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_data: got %h want deadbeef", r); end
        access(1, 1'b0, 1'b1, 1'b1, 32'h2003, LEN_B, 32'h000000A5, 1'b0, r, de, hc);
        access(1, 1'b1, 1'b0, 1'b0, 32'h2003, LEN_B, 32'h0, 1'b0, r, de, hc);
        checks++; if (r !== 32'h000000A5) begin errors++; $display("FAIL lb_data: got %h want 000000a5", r); end
        access(1, 1'b1, 1'b0, 1'b0, 32'h2000, LEN_W, 32'h0, 1'b0, r, de, hc);
        checks++; if (r !== 32'hA5ADBEEF) begin errors++; $display("FAIL lw_after_sb: got %h want a5adbeef", r); end
        access(1, 1'b0, 1'b1, 1'b1, 32'h2002, LEN_H, 32'h00001234, 1'b0, r, de, hc);
        access(1, 1'b1, 1'b0, 1'b0, 32'h2002, LEN_H, 32'h0, 1'b0, r, de, hc);
        checks++; if (r !== 32'h00001234) begin errors++; $display("FAIL lh_data: got %h want 00001234", r); end
        access(1, 1'b1, 1'b0, 1'b0, 32'h2000, LEN_W, 32'h0, 1'b0, r, de, hc);
        checks++; if (r !== 32'h1234BEEF) begin errors++; $display("FAIL lw_after_sh: got %h want 1234beef", r); end
        checks++; if (de !== 1'b0) begin errors++; $display("FAIL derr_clean: got %b want 0", de); end
    endtask

    task automatic test_errors();
        logic [31:0] r; logic de; int hc;
        access(1, 1'b1, 1'b0, 1'b0, 32'h2001, LEN_W, 32'h0, 1'b0, r, de, hc);
        checks++; if (r !== 32'd0) begin errors++; $display("FAIL misalign_data: got %h want 0", r); end
        checks++; if (de !== 1'b1) begin errors++; $display("FAIL misalign_derr: got %b want 1", de); end
        checks++; if (hc !== 3) begin errors++; $display("FAIL misalign_hlt_cycles: got %0d want 3", hc); end
        @(negedge CLK); derr_clr[1] = 1'b1;
        @(posedge CLK); #1; derr_clr[1] = 1'b0; exp_derr[1] = 1'b0;
        checks++; if (derr[1] !== 1'b0) begin errors++; $display("FAIL derr_clear: got %b want 0", derr[1]); end
        access(1, 1'b0, 1'b1, 1'b1, 32'h3000, LEN_W, 32'h55555555, 1'b0, r, de, hc);
        checks++; if (de !== 1'b1) begin errors++; $display("FAIL oow_derr: got %b want 1", de); end
        checks++; if (r !== 32'd0) begin errors++; $display("FAIL oow_data: got %h want 0", r); end
        derr_clr[1] = 1'b1;
        access(1, 1'b1, 1'b0, 1'b0, 32'h2000, LEN_W, 32'h0, 1'b0, r, de, hc);
        derr_clr[1] = 1'b0; exp_derr[1] = 1'b0;
        checks++; if (r !== 32'h1234BEEF) begin errors++; $display("FAIL ram_unchanged: got %h want 1234beef", r); end
        checks++; if (de !== 1'b0) begin errors++; $display("FAIL derr_after_clr: got %b want 0", de); end
        derr_clr[1] = 1'b1;
        access(1, 1'b1, 1'b0, 1'b0, 32'h2002, LEN_W, 32'h0, 1'b0, r, de, hc);
        checks++; if (de !== 1'b1) begin errors++; $display("FAIL set_wins: got %b want 1", de); end
        checks++; if (derr[1] !== 1'b0) begin errors++; $display("FAIL clr_after_set: got %b want 0", derr[1]); end
        derr_clr[1] = 1'b0; exp_derr[1] = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] r; logic de; int hc;
        access(0, 1'b0, 1'b1, 1'b1, 32'h2004, LEN_W, 32'h11111111, 1'b1, r, de, hc);
        checks++; if (hc !== 2) begin errors++; $display("FAIL b2b_sw_hlt_cycles: got %0d want 2", hc); end
        checks++; if (hlt[0] !== 1'b1) begin errors++; $display("FAIL b2b_gap: got hlt %b want 1 after one-cycle gap", hlt[0]); end
        access(0, 1'b1, 1'b0, 1'b0, 32'h2004, LEN_W, 32'h0, 1'b0, r, de, hc);
        checks++; if (hc !== 2) begin errors++; $display("FAIL b2b_lw_hlt_cycles: got %0d want 2", hc); end
        checks++; if (r !== 32'h11111111) begin errors++; $display("FAIL b2b_data: got %h want 11111111", r); end
    endtask

    task automatic test_random();
        logic [31:0] r, a, wd; logic de, rd, wr, rw; logic [2:0] len; int hc, kind, n;
        for (int u = 0; u < 2; u++) begin
            for (int w = 0; w < 16; w++) begin
                access(u, 1'b0, 1'b1, 1'b1, BASE + 32'(4 * w), LEN_W, $urandom, 1'b0, r, de, hc);
                checks++; if (hc !== u + 2) begin errors++; $display("FAIL fill_hlt_cycles[%0d]: got %0d want %0d", u, hc, u + 2); end
            end
            for (int t = 0; t < 40; t++) begin
                kind = int'($urandom_range(0, 9));
                n = 1 << int'($urandom_range(0, 2));
                len = 3'(n);
                a = BASE + (32'($urandom_range(0, 63)) & ~32'(n - 1));
                wr = 1'($urandom_range(0, 1)); rd = !wr; rw = wr; wd = $urandom;
                if (kind == 7) begin
                    if (n == 1) len = LEN_W;
                    a = a | 32'd1;
                end else if (kind == 8) begin
                    a = $urandom_range(0, 1) ? BASE - 32'(4 * $urandom_range(1, 64))
                                             : BASE + 32'h1000 + 32'(4 * $urandom_range(0, 64));
                end else if (kind == 9) begin
                    rd = 1'($urandom_range(0, 1)); wr = 1'($urandom_range(0, 1));
                    rw = 1'($urandom_range(0, 1)); len = 3'($urandom_range(0, 7));
                end
                access(u, rd, wr, rw, a, len, wd, 1'b0, r, de, hc);
                checks++; if (hc !== u + 2) begin errors++; $display("FAIL rnd_hlt_cycles[%0d]: got %0d want %0d", u, hc, u + 2); end
                checks++; if (r !== exp_datai[u]) begin errors++; $display("FAIL rnd_data[%0d] addr %h len %b: got %h want %h", u, a, len, r, exp_datai[u]); end
                checks++; if (de !== exp_derr[u]) begin errors++; $display("FAIL rnd_derr[%0d]: got %b want %b", u, de, exp_derr[u]); end
                if (exp_derr[u] && $urandom_range(0, 2) == 0) begin
                    @(negedge CLK); derr_clr[u] = 1'b1;
                    @(posedge CLK); #1; derr_clr[u] = 1'b0; exp_derr[u] = 1'b0;
                    checks++; if (derr[u] !== 1'b0) begin errors++; $display("FAIL rnd_clear[%0d]: got %b want 0", u, derr[u]); end
                end
            end
        end
    endtask

    task automatic test_abort();
        logic [31:0] r; logic de; int hc;
        @(negedge CLK);
        drd[1] = 1'b0; dwr[1] = 1'b1; drw[1] = 1'b1; daddr[1] = 32'h2008;
        dlen[1] = LEN_W; datao[1] = 32'hCAFEF00D; das[1] = 1'b1;
        @(posedge CLK); #1;
        checks++; if (hlt[1] !== 1'b1) begin errors++; $display("FAIL abort_busy_hlt: got %b want 1", hlt[1]); end
        resn[1] = 1'b0;
        #1;
        checks++; if (hlt[1] !== 1'b0) begin errors++; $display("FAIL abort_hlt_drop: got %b want 0", hlt[1]); end
        das[1] = 1'b0;
        @(posedge CLK); @(negedge CLK);
        checks++; if (datai[1] !== 32'd0) begin errors++; $display("FAIL abort_datai: got %h want 0", datai[1]); end
        resn[1] = 1'b1;
        exp_datai[1] = 32'd0; exp_derr[1] = 1'b0;
        access(1, 1'b1, 1'b0, 1'b0, 32'h2008, LEN_W, 32'h0, 1'b0, r, de, hc);
        checks++; if (r !== exp_datai[1]) begin errors++; $display("FAIL abort_no_write: got %h want %h", r, exp_datai[1]); end
        checks++; if (hc !== 3) begin errors++; $display("FAIL abort_next_hlt_cycles: got %0d want 3", hc); end
    endtask

    initial begin
        test_reset();
        test_word_byte_half();
        test_errors();
        test_back_to_back();
        test_random();
        test_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
